// File: rtl/div_ratio_pkg.sv
// div_ratio_pkg: shared widths, FSM states and helpers for the divided-clock ratio checker
package div_ratio_pkg;

    localparam int CNT_W = 10;
    localparam int DIV_W = 8;
    localparam int THR_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_e;

    function automatic logic [THR_W-1:0] abs_diff(input logic [CNT_W-1:0] a, input logic [DIV_W-1:0] b);
        return (a >= CNT_W'(b)) ? {1'b0, a - CNT_W'(b)} : {1'b0, CNT_W'(b) - a};
    endfunction

endpackage

// File: rtl/div_clk_sync.sv
// div_clk_sync: synchronizes div_clk into the clk_in domain and pulses on each rising edge
module div_clk_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], d_i};
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

endmodule

// File: rtl/div_ratio_checker.sv
// div_ratio_checker: measures div_clk periods in clk_in cycles and checks them against divide_by
module div_ratio_checker
    import div_ratio_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_CNT     = 4,
    parameter int TOL          = 0,
    parameter int TIMEOUT_MULT = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic [DIV_W-1:0] divide_by,
    input  logic             power_down,
    input  logic             err_clr,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_ratio,
    output logic             ratio_ok,
    output logic             lock,
    output logic             timeout,
    output logic             err_sticky,
    output logic             range_err
);

    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);
    localparam logic [THR_W-1:0] TOL_V    = THR_W'(TOL);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] meas_ratio_q, meas_ratio_d;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       lock_cnt_q, lock_cnt_d;
    logic [THR_W-1:0] thr;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic             meas_valid_q, meas_valid_d;
    logic             ratio_ok_q, ratio_ok_d;
    logic             timeout_q, timeout_d;
    logic             rise, ok, tmo_hit, div_chg;

    div_clk_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_in),
        .rst_ni(rst_n),
        .d_i   (div_clk),
        .rise_o(rise)
    );

    assign range_err = ~power_down & (divide_by < DIV_W'(2));
    assign div_chg   = divide_by != div_q;
    assign thr       = THR_W'(TIMEOUT_MULT * int'(divide_by));
    assign tmo_hit   = {1'b0, cnt_q} >= thr;
    assign ok        = abs_diff(cnt_q, divide_by) <= TOL_V;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Priority: idle conditions, ratio change, rise (beats a coincident timeout), timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_inc;
        lock_cnt_d   = lock_cnt_q;
        lock_d       = lock_q;
        err_d        = err_clr ? 1'b0 : err_q;
        meas_valid_d = 1'b0;
        meas_ratio_d = meas_ratio_q;
        ratio_ok_d   = ratio_ok_q;
        timeout_d    = 1'b0;
        if (power_down || range_err) begin
            state_d    = IDLE;
            cnt_d      = '0;
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ARM;
            cnt_d   = '0;
        end else if (div_chg) begin
            state_d    = ARM;
            cnt_d      = '0;
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end else if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_W'(1);
            if (state_q == MEASURE) begin
                meas_valid_d = 1'b1;
                meas_ratio_d = cnt_q;
                ratio_ok_d   = ok;
                lock_cnt_d   = ok ? ((lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1) : 4'd0;
                lock_d       = ok && (lock_cnt_d == LOCK_MAX);
                err_d        = ok ? err_d : 1'b1;
            end
        end else if (tmo_hit) begin
            state_d    = ARM;
            cnt_d      = '0;
            lock_cnt_d = '0;
            lock_d     = 1'b0;
            err_d      = 1'b1;
            timeout_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            lock_cnt_q   <= '0;
            lock_q       <= 1'b0;
            err_q        <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_ratio_q <= '0;
            ratio_ok_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= divide_by;
            lock_cnt_q   <= lock_cnt_d;
            lock_q       <= lock_d;
            err_q        <= err_d;
            meas_valid_q <= meas_valid_d;
            meas_ratio_q <= meas_ratio_d;
            ratio_ok_q   <= ratio_ok_d;
            timeout_q    <= timeout_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign meas_ratio = meas_ratio_q;
    assign ratio_ok   = ratio_ok_q;
    assign lock       = lock_q;
    assign timeout    = timeout_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_div_ratio_checker.sv
// tb_div_ratio_checker: randomized divider stimulus checked against an event-level period model
module tb_div_ratio_checker;

    localparam int LOCK_CNT = 4;
    localparam int TOL      = 0;
    localparam int TMULT    = 4;

    logic       clk_in     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       div_clk    = 1'b0;
    logic [7:0] divide_by  = 8'd2;
    logic       power_down = 1'b1;
    logic       err_clr    = 1'b0;
    logic       meas_valid, ratio_ok, lock, timeout, err_sticky, range_err;
    logic [9:0] meas_ratio;

    int tests = 0, fails = 0;
    int div_n = 2, ph = 0;
    bit div_run = 1'b1, quiet = 1'b1;
    int nxt_n = 2, nxt_d = 2, chg_req = 0, chg_ack = 0;
    int exp_n = 2, exp_d = 2;
    int run_ok = 0, run_meas = 0, meas_cnt = 0, tmo_cnt = 0, cyc = 0, last_meas = 0, last_tmo = 0;
    bit err_m = 1'b0, clr_prev = 1'b0;

    div_ratio_checker #(
        .SYNC_STAGES (2),
        .LOCK_CNT    (LOCK_CNT),
        .TOL         (TOL),
        .TIMEOUT_MULT(TMULT)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .div_clk   (div_clk),
        .divide_by (divide_by),
        .power_down(power_down),
        .err_clr   (err_clr),
        .meas_valid(meas_valid),
        .meas_ratio(meas_ratio),
        .ratio_ok  (ratio_ok),
        .lock      (lock),
        .timeout   (timeout),
        .err_sticky(err_sticky),
        .range_err (range_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural divider: period div_n clk_in cycles, high for the first half.
    initial forever begin
        @(posedge clk_in);
        #1;
        if (!div_run) begin
            div_clk = 1'b0;
            ph = div_n - 1;
        end else begin
            ph = (ph + 1 >= div_n) ? 0 : ph + 1;
            div_clk = (ph < div_n / 2);
        end
    end

    // Reference model: every measured period equals the divider period, lock after
    // LOCK_CNT consecutive good periods, sticky error on any bad period or timeout.
    always @(negedge clk_in) begin
        bit ok;
        cyc++;
        if (clr_prev) err_m = 1'b0;
        if (!rst_n) begin
            err_m = 1'b0;
            run_ok = 0;
            run_meas = 0;
        end
        if (quiet) check("idle_meas", meas_valid, 0);
        else if (meas_valid) begin
            ok = ((exp_n > exp_d) ? exp_n - exp_d : exp_d - exp_n) <= TOL;
            meas_cnt++;
            check("meas_ratio", meas_ratio, exp_n);
            check("ratio_ok", ratio_ok, ok);
            if (run_meas > 0) check("period", cyc - last_meas, exp_n);
            run_meas++;
            run_ok = ok ? run_ok + 1 : 0;
            if (!ok) err_m = 1'b1;
            check("lock", lock, run_ok >= LOCK_CNT);
            check("err_sticky", err_sticky, err_m);
            last_meas = cyc;
        end
        if (timeout) begin
            tmo_cnt++;
            last_tmo = cyc;
            err_m = 1'b1;
            run_ok = 0;
            run_meas = 0;
            check("tmo_lock", lock, 0);
            check("tmo_err", err_sticky, err_m);
        end
        if (chg_req != chg_ack) begin
            exp_n = nxt_n;
            exp_d = nxt_d;
            run_ok = 0;
            run_meas = 0;
            chg_ack = chg_req;
        end
        clr_prev = err_clr;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic set_cfg(input int n, input int d);
        power_down = 1'b1;
        tick(1);
        quiet = 1'b1;
        div_n = n;
        divide_by = 8'(d);
        nxt_n = n;
        nxt_d = d;
        chg_req++;
        tick(6);
        quiet = 1'b0;
        power_down = 1'b0;
    endtask

    task automatic wait_meas(input int k);
        int target = meas_cnt + k;
        int budget = (k + 3) * div_n + 40;
        for (int i = 0; i < budget && meas_cnt < target; i++) tick(1);
        if (meas_cnt < target) check("meas_wait", meas_cnt, target);
    endtask

    task automatic wait_tmo(input int k);
        int target = tmo_cnt + k;
        for (int i = 0; i < 400 && tmo_cnt < target; i++) tick(1);
        if (tmo_cnt < target) check("tmo_wait", tmo_cnt, target);
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic change_running(input int n);
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (ph == 0 && div_clk) break;
        end
        div_n = n;
        divide_by = 8'(n);
        nxt_n = n;
        nxt_d = n;
        chg_req++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_meas_ratio"}, meas_ratio, 0);
        check({tag, "_ratio_ok"}, ratio_ok, 0);
        check({tag, "_lock"}, lock, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_err"}, err_sticky, 0);
    endtask

    initial begin
        int sweep[8];
        int d, n, t1, t0;
        tick(3);
        check_zero("rst");
        check("rst_range_err", range_err, 0);
        rst_n = 1'b1;

        set_cfg(2, 2);
        wait_meas(6);
        check("d2_lock", lock, 1);
        check("d2_err", err_sticky, 0);

        sweep = '{4, 8, 16, 32, 64, 0, 0, 0};
        for (int i = 5; i < 8; i++) sweep[i] = $urandom_range(3, 60);
        foreach (sweep[i]) begin
            set_cfg(sweep[i], sweep[i]);
            wait_meas(5);
            check("sweep_lock", lock, 1);
            check("sweep_err", err_sticky, 0);
        end

        set_cfg(10, 8);
        wait_meas(2);
        check("mm_err", err_sticky, 1);
        check("mm_lock", lock, 0);
        tick(1);
        clr_pulse();
        check("mm_clr", err_sticky, 0);
        wait_meas(1);
        check("mm_reerr", err_sticky, 1);
        for (int i = 0; i < 2; i++) begin
            d = $urandom_range(3, 30);
            n = $urandom_range(0, 1) ? d + 1 + $urandom_range(0, 2) : d - 1;
            set_cfg(n, d);
            wait_meas(3);
            check("rmm_lock", lock, 0);
        end

        set_cfg(16, 16);
        wait_meas(5);
        clr_pulse();
        check("pre_tmo_err", err_sticky, 0);
        t0 = tmo_cnt;
        div_run = 1'b0;
        wait_tmo(1);
        check("tmo_gap", last_tmo - last_meas, TMULT * 16);
        check("tmo_err_after", err_sticky, 1);
        t1 = last_tmo;
        wait_tmo(1);
        check("tmo_rearm_gap", last_tmo - t1, TMULT * 16 + 1);
        check("tmo_count", tmo_cnt, t0 + 2);
        div_run = 1'b1;
        wait_meas(5);
        check("tmo_relock", lock, 1);

        clr_pulse();
        set_cfg(8, 8);
        wait_meas(5);
        check("pre_chg_lock", lock, 1);
        change_running(16);
        tick(2);
        check("chg_lock", lock, 0);
        check("chg_err", err_sticky, 0);
        wait_meas(5);
        check("chg_relock", lock, 1);
        check("chg_err_end", err_sticky, 0);

        tick(5);
        power_down = 1'b1;
        tick(1);
        quiet = 1'b1;
        check("pd_lock", lock, 0);
        tick(30);

        set_cfg(16, 16);
        wait_meas(5);
        tick(7);
        rst_n = 1'b0;
        quiet = 1'b1;
        #1;
        check_zero("midrst");
        tick(3);
        rst_n = 1'b1;
        quiet = 1'b0;
        wait_meas(5);
        check("rst_relock", lock, 1);

        divide_by = 8'd1;
        tick(1);
        quiet = 1'b1;
        check("range_err_hi", range_err, 1);
        check("range_lock", lock, 0);
        tick(40);
        check("range_err_hold", range_err, 1);
        power_down = 1'b1;
        #1;
        check("range_pd", range_err, 0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
